// File: rtl/sync_chain_pkg.sv
// Shared helpers for the multi-lane register chain: counter sizing and lane packing.
package sync_chain_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Fill counter must be able to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int lane_offset(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sync_chain_lane.sv
// One lane of the chain: DEPTH-stage shift register, saturating fill counter and,
// when SYNC_CHAIN_EDGE_EN is defined, registered per-bit rise/fall pulses.
module sync_chain_lane
    import sync_chain_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             ena_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int               CNT_W   = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (ena_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
        valid_d = (count_d == CNT_MAX);
    end

    // NOTE: the stage array is ordinary flops that must restart at RST_VAL, so it is reset
    // like any other state; non-blocking assignments keep the shift order-independent.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= RST_VAL;
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= RST_VAL;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (ena_i) begin
                stage_q[0] <= data_i;
                for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
            end
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = stage_q[DEPTH-1];
    assign valid_o = valid_q;

`ifdef SYNC_CHAIN_EDGE_EN
    logic [WIDTH-1:0] new_out;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // The value about to appear on data_o after this edge.
    if (DEPTH == 1) begin : g_new_from_input
        assign new_out = data_i;
    end else begin : g_new_from_stage
        assign new_out = stage_q[DEPTH-2];
    end

    // Gating on valid_q hides the RST_VAL-to-data transitions seen while filling.
    always_comb begin
        rise_d = '0;
        fall_d = '0;
        if (ena_i && valid_q) begin
            rise_d = new_out & ~data_o;
            fall_d = ~new_out & data_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q <= '0;
            fall_q <= '0;
        end else if (flush_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule

// File: rtl/sync_chain_multi.sv
// Multi-lane synchroniser / fixed-latency delay line built from independent lanes.
// Define SYNC_CHAIN_EDGE_EN to enable the registered rise_o/fall_o pulse outputs.
module sync_chain_multi
    import sync_chain_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 2,
    parameter int               CHANNELS = 1,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [CHANNELS-1:0]       ena_i,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    output logic [CHANNELS*WIDTH-1:0] data_o,
    output logic [CHANNELS-1:0]       valid_o,
    output logic [CHANNELS*WIDTH-1:0] rise_o,
    output logic [CHANNELS*WIDTH-1:0] fall_o
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        localparam int OFS = lane_offset(c, WIDTH);

        sync_chain_lane #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .RST_VAL (RST_VAL)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .ena_i   (ena_i[c]),
            .data_i  (data_i[OFS +: WIDTH]),
            .data_o  (data_o[OFS +: WIDTH]),
            .valid_o (valid_o[c]),
            .rise_o  (rise_o[OFS +: WIDTH]),
            .fall_o  (fall_o[OFS +: WIDTH])
        );
    end

endmodule
